gate_seq_arb: RTL

Round-robin arbiter and sequencer that shares one two-stage gate datapath among NREQ requesters. The datapath registers A&B in one cycle, then registers the combined XOR/AND result of A, B, C and the stored term the next cycle. This block grants one requester and latches its A/B/C operand triple. It drives the triple into the datapath in the required two-cycle order, samples the result and returns it tagged with the requester id. It also owns the datapath's synchronous reset line and uses it for power-up clearing and aborts.

---
 rtl/gate_seq_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gate_seq_arb.sv
// Round-robin arbiter/sequencer sharing one two-stage gate datapath among NREQ requesters.
// Grants one requester, steps its A/B/C through LOAD/EVAL, captures dp_d_i in CAPT.
module gate_seq_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [NREQ-1:0] req_a_i,
  input  logic [NREQ-1:0] req_b_i,
  input  logic [NREQ-1:0] req_c_i,
  output logic [NREQ-1:0] req_ready_o,
  output logic            dp_a_o,
  output logic            dp_b_o,
  output logic            dp_c_o,
  output logic            dp_reset_o,
  input  logic            dp_d_i,
  output logic            resp_valid_o,
  output logic [IDW-1:0]  resp_id_o,
  output logic            resp_d_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_CAPT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic           dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
  logic           dp_reset_q, dp_reset_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic           resp_d_q, resp_d_d;

  logic           window;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           grant;
  int unsigned    cand;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    win_found   = 1'b0;
    win_id      = '0;
    cand        = 0;
    req_ready_o = '0;
    window      = (state_q == S_IDLE || state_q == S_CAPT) && !flush_i && !dp_reset_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req_valid_i[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
    grant = window && win_found;
    if (grant) req_ready_o[win_id] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    dp_a_d       = 1'b0;
    dp_b_d       = 1'b0;
    dp_c_d       = 1'b0;
    dp_reset_d   = flush_i;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_d_d     = resp_d_q;

    case (state_q)
      S_IDLE: if (grant) state_d = S_LOAD;
      S_LOAD: state_d = S_EVAL;
      S_EVAL: state_d = S_CAPT;
      S_CAPT: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_d_d     = dp_d_i;
        state_d      = grant ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      op_a_d   = req_a_i[win_id];
      op_b_d   = req_b_i[win_id];
      op_c_d   = req_c_i[win_id];
      id_d     = win_id;
      rr_ptr_d = win_id;
    end

    // Abort wins over the CAPT response; the aborted transaction is simply dropped.
    if (flush_i) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      resp_d_d     = resp_d_q;
    end

    // Datapath operands are registered, so they follow the state being entered.
    case (state_d)
      S_LOAD: begin
        dp_a_d = op_a_d;
        dp_b_d = op_b_d;
      end
      S_EVAL: begin
        dp_a_d = op_a_d;
        dp_b_d = op_b_d;
        dp_c_d = op_c_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      id_q         <= '0;
      op_a_q       <= 1'b0;
      op_b_q       <= 1'b0;
      op_c_q       <= 1'b0;
      dp_a_q       <= 1'b0;
      dp_b_q       <= 1'b0;
      dp_c_q       <= 1'b0;
      dp_reset_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_c_q       <= dp_c_d;
      dp_reset_q   <= dp_reset_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_d_q     <= resp_d_d;
    end
  end

  assign dp_a_o       = dp_a_q;
  assign dp_b_o       = dp_b_q;
  assign dp_c_o       = dp_c_q;
  assign dp_reset_o   = dp_reset_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_d_o     = resp_d_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
